// File: rtl/wave_switch_ctrl.sv
// Waveform select controller: fades the output to silence, switches the
// waveform mux while muted, then fades back up to unity gain.
module wave_switch_ctrl #(
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_en,
  input  logic        i_next,
  input  logic        i_prev,
  input  logic        i_sel_load,
  input  logic [2:0]  i_sel_req,
  input  logic [15:0] i_data,
  output logic [2:0]  o_sel,
  output logic [15:0] o_data,
  output logic [7:0]  o_gain,
  output logic        o_busy
);

  localparam logic [2:0] SEL_MAX    = 3'd4;
  localparam logic [7:0] GAIN_UNITY = 8'd128;
  localparam logic [8:0] STEP       = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    PLAY,
    FADE_OUT,
    SWAP,
    FADE_IN
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  tgt_reg, tgt_next;
  logic [2:0]  sel_reg, sel_next;
  logic [7:0]  gain_reg, gain_next;
  logic [15:0] data_reg, data_next;

  logic [8:0]  gain_sum;
  logic [7:0]  gain_up;
  logic [7:0]  gain_dn;

  logic signed [23:0] data_wide;
  logic signed [23:0] gain_wide;
  logic signed [23:0] product;
  logic               unused_bits;

  // Target tracking runs in every state so the latest request always wins.
  always_comb begin
    tgt_next = tgt_reg;
    if (i_sel_load) begin
      tgt_next = (i_sel_req > SEL_MAX) ? SEL_MAX : i_sel_req;
    end else if (i_next && !i_prev) begin
      tgt_next = (tgt_reg >= SEL_MAX) ? 3'd0 : tgt_reg + 3'd1;
    end else if (i_prev && !i_next) begin
      tgt_next = (tgt_reg == 3'd0 || tgt_reg > SEL_MAX) ? SEL_MAX : tgt_reg - 3'd1;
    end
  end

  // Saturating ramp arithmetic; 9 bits so a 128 step cannot wrap.
  always_comb begin
    gain_sum = {1'b0, gain_reg} + STEP;
    gain_up  = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[7:0];
    gain_dn  = ({1'b0, gain_reg} > STEP) ? (gain_reg - STEP[7:0]) : 8'd0;
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    gain_next  = gain_reg;
    case (state_reg)
      PLAY: begin
        if (tgt_reg != sel_reg) begin
          state_next = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (gain_reg == 8'd0) begin
          state_next = SWAP;
        end else if (i_sample_en) begin
          gain_next = gain_dn;
        end
      end
      SWAP: begin
        sel_next   = tgt_reg;
        state_next = FADE_IN;
      end
      FADE_IN: begin
        // A new target aborts the fade-in and ramps down from where we are.
        if (tgt_reg != sel_reg) begin
          state_next = FADE_OUT;
        end else if (gain_reg == GAIN_UNITY) begin
          state_next = PLAY;
        end else if (i_sample_en) begin
          gain_next = gain_up;
        end
      end
      default: begin
        state_next = PLAY;
      end
    endcase
  end

  // Signed sample times unsigned gain; bits [22:7] give the >>7 result.
  assign data_wide   = {{8{i_data[15]}}, i_data};
  assign gain_wide   = {16'd0, gain_reg};
  assign product     = data_wide * gain_wide;
  assign data_next   = product[22:7];
  assign unused_bits = ^{product[23], product[6:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= PLAY;
      tgt_reg   <= SEL_MAX;
      sel_reg   <= SEL_MAX;
      gain_reg  <= GAIN_UNITY;
      data_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      sel_reg   <= sel_next;
      gain_reg  <= gain_next;
      data_reg  <= data_next;
    end
  end

  assign o_sel  = sel_reg;
  assign o_gain = gain_reg;
  assign o_data = data_reg;
  assign o_busy = (state_reg != PLAY);

endmodule
